hamming_secded_stream: RTL
==========================

# hamming_secded_stream

Pipelined, parametrised Hamming SECDED decoder with valid/ready streaming. Generalises the fixed 15/11 combinational corrector: Hamming order set by a parameter, an overall-parity bit for double-error detection, a detect-only mode, and saturating error-statistics counters. It sits between a stored or transmitted codeword source and the consumer of protected data.

## Interface
- `R`, 4: parity-bit count, legal range 3..6.
  - Codeword width `N = 2^R`.
  - Data width `K = 2^R - 1 - R`.
  - Default gives N=16, K=11.
- `CNT_W`, 16: width of each statistics counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  codeword present.
- `in_ready`  out  1  block accepts the codeword this cycle.
- `in_code`  in  N  codeword.
- `correct_en`  in  1  1 = correct single errors; 0 = detect only. Sampled with `in_code`.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  K  extracted data.
- `out_syndrome`  out  R  Hamming syndrome of the word.
- `err_single`  out  1  single error detected, including an error in the overall-parity bit.
- `err_double`  out  1  uncorrectable double error.
- `cnt_single`  out  CNT_W  saturating count of delivered words with `err_single`.
- `cnt_double`  out  CNT_W  saturating count of delivered words with `err_double`.
- `clr_cnt`  in  1  synchronous clear of both counters.

## Operation
- Codeword layout:
  - Bit i (i < N-1) is Hamming position i+1.
  - Parity bits sit at indices 2^j - 1.
  - Data bit d_k occupies the k-th non-power-of-two position, in ascending order.
  - Bit N-1 is overall parity: XOR of bits 0..N-2, so the whole word XORs to 0.
- Syndrome s is the XOR of the positions of all set bits 0..N-2. Overall check p is the XOR of all N bits.
- Decision:
  - s=0, p=0: clean. Data extracted as is; no flags.
  - s≠0, p=1: single error at position s. `err_single`=1. If `correct_en`, flip bit s-1 before extraction; otherwise extract raw.
  - s=0, p=1: overall-parity bit in error. `err_single`=1; data is unaffected.
  - s≠0, p=0: double error. `err_double`=1; raw extraction, no flip regardless of mode.
- Counters:
  - Increment on the output handshake (`out_valid && out_ready`) according to the delivered flags.
  - Saturate at all-ones.
  - `clr_cnt` wins over a same-cycle increment; the counter becomes 0.

## Timing
- Two-stage pipeline:
  - S1 registers the codeword, s, p and mode.
  - S2 registers data, syndrome and flags.
- Latency: 2 cycles from input handshake to `out_valid` when unstalled. Throughput is 1 word/cycle.
- Stall rule: pipeline enable `adv = !out_valid || out_ready`.
  - S2 loads from S1 when `adv`.
  - S1 loads from the input when `adv` or S1 is empty.
  - `in_ready = adv || !s1_valid`.
- Payload rule: while `out_valid && !out_ready`, all `out_*` payload is held stable. A word is never dropped or duplicated.
- Reset values: `in_ready`=1 (combinational after reset). All of the following are 0:
  - `out_valid`, `out_data`, `out_syndrome`
  - `err_single`, `err_double`
  - `cnt_single`, `cnt_double`
  - both stage valid bits
- Reset asserted mid-stream discards any in-flight words and does not change the counters beyond clearing them.
- Data-dependent outputs are registered. `in_ready` is the only combinational output and depends only on `out_ready` and state.

## Structure
- Shared package holds:
  - function `hamming_data_pos(R, k)`: index of data bit k.
  - function `is_pow2`.
  - localparams N and K derived from R.
- One sub-module, `hamming_syndrome`: purely combinational, N-bit codeword in, s and p out. Instantiated in front of S1.
- Extraction, correction, handshake and counters live in the top.

## Test plan
All scenarios use R=4.
- Clean word: `16'h0000` -> `out_data`=11'h000, s=0, no flags. Then `16'hFFFF` -> 11'h7FF, no flags. Each appears exactly 2 cycles after acceptance.
- Single error, correcting: `16'hFFEF` (bit 4 flipped) with `correct_en`=1 -> `out_data`=11'h7FF, s=5, `err_single`=1, `cnt_single`=1.
- Single error, detect-only: same word with `correct_en`=0 -> `out_data`=11'h7FD, s=5, `err_single`=1.
- Overall-parity and double errors:
  - `16'h8000` -> data 11'h000, s=0, `err_single`=1.
  - `16'h0003` -> data 11'h000, s=3, `err_double`=1, `cnt_double`=1.
- Backpressure: stream 6 back-to-back words while `out_ready` is low for cycles 3-5.
  - `in_ready` drops once S1 and S2 are both full.
  - All 6 results are delivered in order, unchanged.
- Counters and reset:
  - Force `cnt_single` to all-ones via a short CNT_W=2 build -> counter holds at 3.
  - `clr_cnt` concurrent with a single-error handshake -> counter reads 0.
  - `rst_n` low mid-stream -> `out_valid`=0 immediately, with no stale word after release.

Source files
------------

// File: rtl/hamming_secded_stream_pkg.sv
// Shared layout helpers for the Hamming SECDED stream decoder: data-bit placement
// in the codeword and the error-flag record carried down the pipeline.
package hamming_secded_stream_pkg;

  localparam int DEF_R = 4;
  localparam int N     = 2 ** DEF_R;
  localparam int K     = N - 1 - DEF_R;

  typedef struct packed {
    logic single;
    logic dbl;
  } err_flags_t;

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Codeword index of data bit k: the k-th non-power-of-two Hamming position, minus one.
  function automatic int hamming_data_pos(input int r, input int k);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int pos = 1; pos < (1 << r); pos++) begin
      if (!is_pow2(pos)) begin
        if (cnt == k) res = pos - 1;
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_secded_stream_syndrome.sv
// Combinational Hamming syndrome and overall parity of one N-bit codeword.
module hamming_syndrome #(
  parameter int R = 4
) (
  input  logic [2**R-1:0] code_i,
  output logic [R-1:0]    syn_o,
  output logic            par_o
);

  localparam int NW = 2 ** R;

  always_comb begin
    syn_o = '0;
    for (int i = 0; i < NW - 1; i++) begin
      if (code_i[i]) syn_o = syn_o ^ R'(i + 1);
    end
    par_o = ^code_i;
  end

endmodule

// File: rtl/hamming_secded_stream.sv
// Two-stage SECDED decoder with valid/ready flow control and saturating
// single/double error counters updated on the output handshake.
module hamming_secded_stream
  import hamming_secded_stream_pkg::*;
#(
  parameter int R     = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2**R-1:0]        in_code,
  input  logic                   correct_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2**R-2-R:0]      out_data,
  output logic [R-1:0]           out_syndrome,
  output logic                   err_single,
  output logic                   err_double,
  output logic [CNT_W-1:0]       cnt_single,
  output logic [CNT_W-1:0]       cnt_double,
  input  logic                   clr_cnt
);

  localparam int NW = 2 ** R;
  localparam int KW = NW - 1 - R;

  // [0] = S1 occupied, [1] = S2 occupied (drives out_valid)
  logic [1:0]       vld_pipe_q;
  logic [R-1:0]     in_syn;
  logic             in_par;
  logic [KW-1:0]    in_raw;

  logic [KW-1:0]    s1_raw_q;
  logic [R-1:0]     s1_syn_q;
  logic             s1_par_q;
  logic             s1_cen_q;

  logic [KW-1:0]    data_d, data_q;
  logic [R-1:0]     syn_q;
  err_flags_t       err_d, err_q;
  logic             flip_en;

  logic [CNT_W-1:0] cnt_s_d, cnt_s_q, cnt_d_d, cnt_d_q;
  logic             adv, s1_en, out_hs;

  hamming_syndrome #(.R(R)) u_syn (
    .code_i (in_code),
    .syn_o  (in_syn),
    .par_o  (in_par)
  );

  assign adv      = !vld_pipe_q[1] || out_ready;
  assign s1_en    = adv || !vld_pipe_q[0];
  assign in_ready = s1_en;
  assign out_hs   = vld_pipe_q[1] && out_ready;

  // Parity-position bits are dead once the syndrome exists, so S1 keeps only data bits.
  assign flip_en = s1_cen_q && s1_par_q && (s1_syn_q != '0);

  for (genvar k = 0; k < KW; k++) begin : g_data
    localparam int P = hamming_data_pos(R, k);
    assign in_raw[k] = in_code[P];
    assign data_d[k] = s1_raw_q[k] ^ (flip_en && (s1_syn_q == R'(P + 1)));
  end

  always_comb begin
    err_d.single = s1_par_q;
    err_d.dbl    = !s1_par_q && (s1_syn_q != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_raw_q   <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      s1_cen_q   <= 1'b0;
      data_q     <= '0;
      syn_q      <= '0;
      err_q      <= '0;
    end else begin
      if (s1_en) begin
        vld_pipe_q[0] <= in_valid;
        if (in_valid) begin
          s1_raw_q <= in_raw;
          s1_syn_q <= in_syn;
          s1_par_q <= in_par;
          s1_cen_q <= correct_en;
        end
      end
      if (adv) begin
        vld_pipe_q[1] <= vld_pipe_q[0];
        if (vld_pipe_q[0]) begin
          data_q <= data_d;
          syn_q  <= s1_syn_q;
          err_q  <= err_d;
        end
      end
    end
  end

  always_comb begin
    cnt_s_d = cnt_s_q;
    cnt_d_d = cnt_d_q;
    if (clr_cnt) begin
      cnt_s_d = '0;
      cnt_d_d = '0;
    end else if (out_hs) begin
      if (err_q.single && (cnt_s_q != '1)) cnt_s_d = cnt_s_q + CNT_W'(1);
      if (err_q.dbl    && (cnt_d_q != '1)) cnt_d_d = cnt_d_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_s_q <= '0;
      cnt_d_q <= '0;
    end else begin
      cnt_s_q <= cnt_s_d;
      cnt_d_q <= cnt_d_d;
    end
  end

  assign out_valid    = vld_pipe_q[1];
  assign out_data     = data_q;
  assign out_syndrome = syn_q;
  assign err_single   = err_q.single;
  assign err_double   = err_q.dbl;
  assign cnt_single   = cnt_s_q;
  assign cnt_double   = cnt_d_q;

endmodule
